// File: rtl/bsg_fifo_1r1w_rolly_partial_ack.sv
// Speculative 1r1w FIFO with checkpointing on both sides.
// The write side stages entries and then commits or drops them as a batch.
// The read side consumes entries speculatively, then either releases a
// programmable number of them (partial ack) or rewinds to the oldest
// unacked entry. Depth may be any integer >= 2. Pointers wrap explicitly.

module bsg_fifo_1r1w_rolly_partial_ack #(
  parameter int width_p = 8,
  parameter int els_p = 5,
  parameter int ready_then_valid_p = 0,
  localparam int cnt_width_lp = $clog2(els_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [width_p-1:0]      data_i,
  input  logic                    v_i,
  output logic                    ready_o,
  input  logic                    commit_v_i,
  input  logic                    commit_not_drop_i,
  input  logic                    clr_v_i,
  output logic [width_p-1:0]      data_o,
  output logic                    v_o,
  input  logic                    yumi_i,
  input  logic                    rollback_v_i,
  input  logic                    ack_v_i,
  input  logic [cnt_width_lp-1:0] ack_cnt_i,
  output logic [cnt_width_lp-1:0] free_cnt_o,
  output logic [cnt_width_lp-1:0] readable_cnt_o,
  output logic [cnt_width_lp-1:0] unacked_cnt_o,
  output logic [cnt_width_lp-1:0] uncommitted_cnt_o
);

  localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;

  // Increment a pointer, wrapping from els_p-1 back to 0.
  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    if (p == ptr_width_lp'(els_p - 1)) begin
      return '0;
    end else begin
      return p + ptr_width_lp'(1);
    end
  endfunction

  // Advance a pointer by a count in [0, els_p], modulo els_p.
  function automatic logic [ptr_width_lp-1:0] ptr_add(input logic [ptr_width_lp-1:0] p,
                                                      input logic [cnt_width_lp-1:0] n);
    logic [cnt_width_lp:0] sum;
    sum = (cnt_width_lp+1)'(p) + (cnt_width_lp+1)'(n);
    if (sum >= (cnt_width_lp+1)'(els_p)) begin
      sum = sum - (cnt_width_lp+1)'(els_p);
    end else begin
      sum = sum;
    end
    return ptr_width_lp'(sum);
  endfunction

  logic [width_p-1:0] mem [els_p];

  logic [ptr_width_lp-1:0] ackp, rdp, wcp, wrp;
  logic [cnt_width_lp-1:0] readable_cnt, unacked_cnt, uncommitted_cnt;

  logic [ptr_width_lp-1:0] ackp_n, rdp_n, wcp_n, wrp_n;
  logic [ptr_width_lp-1:0] rdp_adv, wrp_adv;
  logic [cnt_width_lp-1:0] readable_n, unacked_n, uncommitted_n;
  logic [cnt_width_lp-1:0] ack_amt, unc_adv, rewound, yumi_amt, enq_amt;
  logic enq;

  assign free_cnt_o = cnt_width_lp'(els_p) - unacked_cnt - readable_cnt - uncommitted_cnt;
  assign ready_o = ~clr_v_i & (free_cnt_o != '0);
  assign v_o = ~rollback_v_i & (readable_cnt != '0);
  assign data_o = mem[rdp];
  assign enq = v_i & ((ready_then_valid_p != 0) ? 1'b1 : ready_o);

  assign readable_cnt_o = readable_cnt;
  assign unacked_cnt_o = unacked_cnt;
  assign uncommitted_cnt_o = uncommitted_cnt;

  // Storage write port; dropped writes land in free slots and are harmless.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem[wrp] <= data_i;
    end
  end

  // Next-state for pointers and region counts; clr dominates commit/drop.
  always_comb begin
    ack_amt  = ack_v_i ? ack_cnt_i : '0;
    yumi_amt = cnt_width_lp'(yumi_i);
    enq_amt  = cnt_width_lp'(enq);
    ackp_n   = ptr_add(ackp, ack_amt);
    rdp_adv  = yumi_i ? ptr_inc(rdp) : rdp;
    wrp_adv  = enq ? ptr_inc(wrp) : wrp;
    unc_adv  = uncommitted_cnt + enq_amt;
    rewound  = unacked_cnt - ack_amt;
    rdp_n         = rdp_adv;
    unacked_n     = unacked_cnt + yumi_amt - ack_amt;
    readable_n    = readable_cnt - yumi_amt;
    wcp_n         = wcp;
    wrp_n         = wrp_adv;
    uncommitted_n = unc_adv;

    // Rollback rewinds the read head to the post-ack oldest entry.
    if (rollback_v_i) begin
      rdp_n      = ackp_n;
      unacked_n  = '0;
      readable_n = readable_cnt + rewound;
    end else begin
      rdp_n = rdp_adv;
    end

    // clr uses the pre-rollback read head so rewound entries stay readable.
    if (clr_v_i) begin
      wrp_n         = rdp_adv;
      wcp_n         = rdp_adv;
      uncommitted_n = '0;
      readable_n    = rollback_v_i ? rewound : '0;
    end else if (commit_v_i & commit_not_drop_i) begin
      wcp_n         = wrp_adv;
      uncommitted_n = '0;
      readable_n    = readable_n + unc_adv;
    end else if (commit_v_i) begin
      wrp_n         = wcp;
      uncommitted_n = '0;
    end else begin
      wrp_n         = wrp_adv;
      uncommitted_n = unc_adv;
    end
  end

  // State register with synchronous reset that overrides every input.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ackp            <= '0;
      rdp             <= '0;
      wcp             <= '0;
      wrp             <= '0;
      readable_cnt    <= '0;
      unacked_cnt     <= '0;
      uncommitted_cnt <= '0;
    end else begin
      ackp            <= ackp_n;
      rdp             <= rdp_n;
      wcp             <= wcp_n;
      wrp             <= wrp_n;
      readable_cnt    <= readable_n;
      unacked_cnt     <= unacked_n;
      uncommitted_cnt <= uncommitted_n;
    end
  end

`ifndef SYNTHESIS
  bsg_fifo_1r1w_rolly_partial_ack_checker #(
    .els_p(els_p),
    .ready_then_valid_p(ready_then_valid_p),
    .cnt_width_p(cnt_width_lp)
  ) checker_inst (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .v_i(v_i),
    .v_o(v_o),
    .yumi_i(yumi_i),
    .rollback_v_i(rollback_v_i),
    .ack_v_i(ack_v_i),
    .ack_cnt_i(ack_cnt_i),
    .free_cnt(free_cnt_o),
    .readable_cnt(readable_cnt),
    .unacked_cnt(unacked_cnt),
    .uncommitted_cnt(uncommitted_cnt)
  );
`endif

endmodule

// Protocol and consistency checks for the rolly FIFO.
module bsg_fifo_1r1w_rolly_partial_ack_checker #(
  parameter int els_p = 5,
  parameter int ready_then_valid_p = 0,
  parameter int cnt_width_p = 3
) (
  input logic                   clk_i,
  input logic                   reset_i,
  input logic                   v_i,
  input logic                   v_o,
  input logic                   yumi_i,
  input logic                   rollback_v_i,
  input logic                   ack_v_i,
  input logic [cnt_width_p-1:0] ack_cnt_i,
  input logic [cnt_width_p-1:0] free_cnt,
  input logic [cnt_width_p-1:0] readable_cnt,
  input logic [cnt_width_p-1:0] unacked_cnt,
  input logic [cnt_width_p-1:0] uncommitted_cnt
);

  logic [cnt_width_p+1:0] used_sum;
  assign used_sum = (cnt_width_p+2)'(readable_cnt) + (cnt_width_p+2)'(unacked_cnt)
                  + (cnt_width_p+2)'(uncommitted_cnt);

  a_yumi_valid: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o));
  a_ack_range:  assert property (@(posedge clk_i) disable iff (reset_i)
                                 !(ack_v_i && (ack_cnt_i > unacked_cnt)));
  a_enq_full:   assert property (@(posedge clk_i) disable iff (reset_i)
                                 !((ready_then_valid_p != 0) && v_i && (free_cnt == '0)));
  a_rb_yumi:    assert property (@(posedge clk_i) disable iff (reset_i) !(rollback_v_i && yumi_i));
  a_cnt_sum:    assert property (@(posedge clk_i) disable iff (reset_i)
                                 used_sum <= (cnt_width_p+2)'(els_p));

endmodule

// File: tb/tb_bsg_fifo_1r1w_rolly_partial_ack.sv
// Directed table-driven bench for the rolly partial-ack FIFO (els_p = 5).
module tb_bsg_fifo_1r1w_rolly_partial_ack;

  localparam int W = 8;
  localparam int E = 5;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic reset_i = 1'b0;
  logic [W-1:0] data_i = '0;
  logic v_i = 1'b0, commit_v_i = 1'b0, commit_not_drop_i = 1'b0, clr_v_i = 1'b0;
  logic yumi_i = 1'b0, rollback_v_i = 1'b0, ack_v_i = 1'b0;
  logic [CW-1:0] ack_cnt_i = '0;
  logic ready_o, v_o;
  logic [W-1:0] data_o;
  logic [CW-1:0] free_cnt_o, readable_cnt_o, unacked_cnt_o, uncommitted_cnt_o;

  int errors = 0;
  int checks = 0;

  bsg_fifo_1r1w_rolly_partial_ack #(.width_p(W), .els_p(E), .ready_then_valid_p(0)) dut (
    .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .v_i(v_i), .ready_o(ready_o),
    .commit_v_i(commit_v_i), .commit_not_drop_i(commit_not_drop_i), .clr_v_i(clr_v_i),
    .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i), .rollback_v_i(rollback_v_i),
    .ack_v_i(ack_v_i), .ack_cnt_i(ack_cnt_i), .free_cnt_o(free_cnt_o),
    .readable_cnt_o(readable_cnt_o), .unacked_cnt_o(unacked_cnt_o),
    .uncommitted_cnt_o(uncommitted_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, v; logic [7:0] d;
    logic cv, cnd, clr, yu, rb, av; logic [2:0] ac;
    logic er, ev; logic [7:0] ed;
    logic [2:0] fr, rd, un, uc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input int rst, v, d, cv, cnd, clr, yu, rb, av, ac,
                              input int er, ev, ed, fr, rd, un, uc);
    vec_t r;
    r.rst = rst[0]; r.v = v[0]; r.d = d[7:0];
    r.cv = cv[0]; r.cnd = cnd[0]; r.clr = clr[0]; r.yu = yu[0]; r.rb = rb[0];
    r.av = av[0]; r.ac = ac[2:0];
    r.er = er[0]; r.ev = ev[0]; r.ed = ed[7:0];
    r.fr = fr[2:0]; r.rd = rd[2:0]; r.un = un[2:0]; r.uc = uc[2:0];
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic idle();
    reset_i = 1'b0; v_i = 1'b0; data_i = '0; commit_v_i = 1'b0; commit_not_drop_i = 1'b0;
    clr_v_i = 1'b0; yumi_i = 1'b0; rollback_v_i = 1'b0; ack_v_i = 1'b0; ack_cnt_i = '0;
  endtask

  task automatic check_state(input int idx, input int er, ev, ed, fr, rd, un, uc);
    chk("ready_o", idx, int'(ready_o), er);
    chk("v_o", idx, int'(v_o), ev);
    if (ev != 0) chk("data_o", idx, int'(data_o), ed);
    chk("free_cnt", idx, int'(free_cnt_o), fr);
    chk("readable_cnt", idx, int'(readable_cnt_o), rd);
    chk("unacked_cnt", idx, int'(unacked_cnt_o), un);
    chk("uncommitted_cnt", idx, int'(uncommitted_cnt_o), uc);
  endtask

  task automatic step_edge();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  initial begin
    //        rst v d     cv cnd clr yu rb av ac  er ev ed     fr rd un uc
    vq.push_back(mk(1,0,0,     0,0,0,0,0,0,0, 1,0,0,     5,0,0,0));
    // enqueue three without commit, then commit
    vq.push_back(mk(0,1,'h11,  0,0,0,0,0,0,0, 1,0,0,     4,0,0,1));
    vq.push_back(mk(0,1,'h12,  0,0,0,0,0,0,0, 1,0,0,     3,0,0,2));
    vq.push_back(mk(0,1,'h13,  0,0,0,0,0,0,0, 1,0,0,     2,0,0,3));
    vq.push_back(mk(0,0,0,     1,1,0,0,0,0,0, 1,1,'h11,  2,3,0,0));
    vq.push_back(mk(0,0,0,     0,0,0,1,0,0,0, 1,1,'h12,  2,2,1,0));
    vq.push_back(mk(0,0,0,     0,0,0,1,0,0,0, 1,1,'h13,  2,1,2,0));
    vq.push_back(mk(0,0,0,     0,0,0,1,0,0,0, 1,0,0,     2,0,3,0));
    vq.push_back(mk(0,0,0,     0,0,0,0,0,1,3, 1,0,0,     5,0,0,0));
    // fill to full with commit on the fifth, partial ack, wrap
    vq.push_back(mk(0,1,'h21,  0,0,0,0,0,0,0, 1,0,0,     4,0,0,1));
    vq.push_back(mk(0,1,'h22,  0,0,0,0,0,0,0, 1,0,0,     3,0,0,2));
    vq.push_back(mk(0,1,'h23,  0,0,0,0,0,0,0, 1,0,0,     2,0,0,3));
    vq.push_back(mk(0,1,'h24,  0,0,0,0,0,0,0, 1,0,0,     1,0,0,4));
    vq.push_back(mk(0,1,'h25,  1,1,0,0,0,0,0, 0,1,'h21,  0,5,0,0));
    vq.push_back(mk(0,0,0,     0,0,0,1,0,0,0, 0,1,'h22,  0,4,1,0));
    vq.push_back(mk(0,0,0,     0,0,0,1,0,0,0, 0,1,'h23,  0,3,2,0));
    vq.push_back(mk(0,0,0,     0,0,0,0,0,1,2, 1,1,'h23,  2,3,0,0));
    vq.push_back(mk(0,1,'h26,  0,0,0,0,0,0,0, 1,1,'h23,  1,3,0,1));
    vq.push_back(mk(0,1,'h27,  1,1,0,0,0,0,0, 0,1,'h23,  0,5,0,0));
    vq.push_back(mk(0,0,0,     0,0,0,1,0,0,0, 0,1,'h24,  0,4,1,0));
    vq.push_back(mk(0,0,0,     0,0,0,1,0,0,0, 0,1,'h25,  0,3,2,0));
    vq.push_back(mk(0,0,0,     0,0,0,1,0,0,0, 0,1,'h26,  0,2,3,0));
    vq.push_back(mk(0,0,0,     0,0,0,1,0,0,0, 0,1,'h27,  0,1,4,0));
    vq.push_back(mk(0,0,0,     0,0,0,1,0,0,0, 0,0,0,     0,0,5,0));
    vq.push_back(mk(0,0,0,     0,0,0,0,0,1,5, 1,0,0,     5,0,0,0));
    // A..D, read three, ack one plus rollback -> B at head
    vq.push_back(mk(0,1,'hA1,  0,0,0,0,0,0,0, 1,0,0,     4,0,0,1));
    vq.push_back(mk(0,1,'hA2,  0,0,0,0,0,0,0, 1,0,0,     3,0,0,2));
    vq.push_back(mk(0,1,'hA3,  0,0,0,0,0,0,0, 1,0,0,     2,0,0,3));
    vq.push_back(mk(0,1,'hA4,  1,1,0,0,0,0,0, 1,1,'hA1,  1,4,0,0));
    vq.push_back(mk(0,0,0,     0,0,0,1,0,0,0, 1,1,'hA2,  1,3,1,0));
    vq.push_back(mk(0,0,0,     0,0,0,1,0,0,0, 1,1,'hA3,  1,2,2,0));
    vq.push_back(mk(0,0,0,     0,0,0,1,0,0,0, 1,1,'hA4,  1,1,3,0));
    vq.push_back(mk(0,0,0,     0,0,0,0,1,1,1, 1,1,'hA2,  2,3,0,0));
    vq.push_back(mk(0,0,0,     0,0,0,1,0,0,0, 1,1,'hA3,  2,2,1,0));
    vq.push_back(mk(0,0,0,     0,0,0,1,0,0,0, 1,1,'hA4,  2,1,2,0));
    vq.push_back(mk(0,0,0,     0,0,0,1,0,0,0, 1,0,0,     2,0,3,0));
    vq.push_back(mk(0,0,0,     0,0,0,0,0,1,3, 1,0,0,     5,0,0,0));
    // X, Y uncommitted, drop with same-cycle Z, then commit W
    vq.push_back(mk(0,1,'hB1,  0,0,0,0,0,0,0, 1,0,0,     4,0,0,1));
    vq.push_back(mk(0,1,'hB2,  0,0,0,0,0,0,0, 1,0,0,     3,0,0,2));
    vq.push_back(mk(0,1,'hB3,  1,0,0,0,0,0,0, 1,0,0,     5,0,0,0));
    vq.push_back(mk(0,1,'hB4,  1,1,0,0,0,0,0, 1,1,'hB4,  4,1,0,0));
    vq.push_back(mk(0,0,0,     0,0,0,1,0,0,0, 1,0,0,     4,0,1,0));
    vq.push_back(mk(0,0,0,     0,0,0,0,0,1,1, 1,0,0,     5,0,0,0));
    // A,B,C committed, D staged, read A, clr+rollback (+commit, clr wins)
    vq.push_back(mk(0,1,'hC1,  0,0,0,0,0,0,0, 1,0,0,     4,0,0,1));
    vq.push_back(mk(0,1,'hC2,  0,0,0,0,0,0,0, 1,0,0,     3,0,0,2));
    vq.push_back(mk(0,1,'hC3,  1,1,0,0,0,0,0, 1,1,'hC1,  2,3,0,0));
    vq.push_back(mk(0,1,'hC4,  0,0,0,0,0,0,0, 1,1,'hC1,  1,3,0,1));
    vq.push_back(mk(0,0,0,     0,0,0,1,0,0,0, 1,1,'hC2,  1,2,1,1));
    vq.push_back(mk(0,0,0,     1,1,1,0,1,0,0, 1,1,'hC1,  4,1,0,0));
    vq.push_back(mk(0,0,0,     0,0,0,1,0,0,0, 1,0,0,     4,0,1,0));
    vq.push_back(mk(0,0,0,     0,0,0,0,0,1,1, 1,0,0,     5,0,0,0));
    // reset mid-stream with other strobes active
    vq.push_back(mk(0,1,'hD1,  0,0,0,0,0,0,0, 1,0,0,     4,0,0,1));
    vq.push_back(mk(0,1,'hD2,  0,0,0,0,0,0,0, 1,0,0,     3,0,0,2));
    vq.push_back(mk(0,1,'hD3,  1,1,0,0,0,0,0, 1,1,'hD1,  2,3,0,0));
    vq.push_back(mk(0,0,0,     0,0,0,1,0,0,0, 1,1,'hD2,  2,2,1,0));
    vq.push_back(mk(1,1,'hEE,  1,1,0,1,0,0,0, 1,0,0,     5,0,0,0));
    // clr with same-cycle yumi keeps the unacked entry
    vq.push_back(mk(0,1,'hE1,  0,0,0,0,0,0,0, 1,0,0,     4,0,0,1));
    vq.push_back(mk(0,1,'hE2,  1,1,0,0,0,0,0, 1,1,'hE1,  3,2,0,0));
    vq.push_back(mk(0,1,'hE3,  0,0,0,0,0,0,0, 1,1,'hE1,  2,2,0,1));
    vq.push_back(mk(0,0,0,     0,0,1,1,0,0,0, 1,0,0,     4,0,1,0));
    vq.push_back(mk(0,0,0,     0,0,0,0,0,1,1, 1,0,0,     5,0,0,0));
    vq.push_back(mk(0,0,0,     0,0,0,0,0,1,0, 1,0,0,     5,0,0,0));
    // fill to full again for the same-cycle corner cases
    vq.push_back(mk(0,1,'hF1,  0,0,0,0,0,0,0, 1,0,0,     4,0,0,1));
    vq.push_back(mk(0,1,'hF2,  0,0,0,0,0,0,0, 1,0,0,     3,0,0,2));
    vq.push_back(mk(0,1,'hF3,  0,0,0,0,0,0,0, 1,0,0,     2,0,0,3));
    vq.push_back(mk(0,1,'hF4,  0,0,0,0,0,0,0, 1,0,0,     1,0,0,4));
    vq.push_back(mk(0,1,'hF5,  1,1,0,0,0,0,0, 0,1,'hF1,  0,5,0,0));
    vq.push_back(mk(0,0,0,     0,0,0,1,0,0,0, 0,1,'hF2,  0,4,1,0));

    idle();
    @(negedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      reset_i = vq[i].rst; v_i = vq[i].v; data_i = vq[i].d;
      commit_v_i = vq[i].cv; commit_not_drop_i = vq[i].cnd; clr_v_i = vq[i].clr;
      yumi_i = vq[i].yu; rollback_v_i = vq[i].rb; ack_v_i = vq[i].av; ack_cnt_i = vq[i].ac;
      step_edge();
      check_state(i, int'(vq[i].er), int'(vq[i].ev), int'(vq[i].ed), int'(vq[i].fr),
                  int'(vq[i].rd), int'(vq[i].un), int'(vq[i].uc));
    end

    // Full: ack does not bypass to ready_o in the same cycle; offered write is refused.
    ack_v_i = 1'b1; ack_cnt_i = 3'd1; v_i = 1'b1; data_i = 8'hEE;
    #1;
    chk("full_ready_same_cycle", 100, int'(ready_o), 0);
    step_edge();
    check_state(101, 1, 1, 'hF2, 1, 4, 0, 0);

    // Rollback forces v_o low in its own cycle.
    rollback_v_i = 1'b1;
    #1;
    chk("rollback_v_o_low", 102, int'(v_o), 0);
    step_edge();
    check_state(103, 1, 1, 'hF2, 1, 4, 0, 0);

    // clr forces ready_o low in its own cycle and discards readable data.
    clr_v_i = 1'b1; v_i = 1'b1; data_i = 8'h99;
    #1;
    chk("clr_ready_low", 104, int'(ready_o), 0);
    step_edge();
    check_state(105, 1, 0, 0, 5, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bsg_fifo_1r1w_rolly_partial_ack.md
Name: bsg_fifo_1r1w_rolly_partial_ack

Overview:
- Speculative 1r1w FIFO with checkpointing on both sides.
- Write side stages entries and then commits or drops them as a batch.
- Read side consumes entries speculatively. It then either acks a programmable count of consumed entries (partial release) or rolls back to the oldest unacked entry.
- Supports arbitrary (non-power-of-two) depth and exports occupancy counts. Sits between a speculative producer (e.g. a packet builder) and a retrying consumer (e.g. a link layer with partial acknowledgement).

Parameters:
- width_p, (none, required), data width in bits.
- els_p, (none, required), entry count; any integer >= 2.
- ready_then_valid_p, 0, 1: enqueue = v_i (producer checks ready_o first); 0: enqueue = v_i & ready_o.
- cnt_width_lp, `BSG_SAFE_CLOG2(els_p+1) (localparam), width of all count ports.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- data_i  in  width_p  enqueue data.
- v_i  in  1  enqueue request.
- ready_o  out  1  enqueue accepted when high.
- commit_v_i  in  1  write-side commit/drop strobe.
- commit_not_drop_i  in  1  1=commit, 0=drop; qualified by commit_v_i.
- clr_v_i  in  1  discard all unread committed and all uncommitted entries.
- data_o  out  width_p  head-of-line read data.
- v_o  out  1  data_o valid.
- yumi_i  in  1  consume head (speculative read).
- rollback_v_i  in  1  rewind read head to oldest unacked entry.
- ack_v_i  in  1  release ack_cnt_i read entries.
- ack_cnt_i  in  cnt_width_lp  number of entries released.
- free_cnt_o  out  cnt_width_lp  free slots.
- readable_cnt_o  out  cnt_width_lp  committed, unread entries.
- unacked_cnt_o  out  cnt_width_lp  read but unacked entries.
- uncommitted_cnt_o  out  cnt_width_lp  written but uncommitted entries.

Behaviour:
- Pointers, all in [0, els_p-1], each incremented with explicit wrap (if ptr == els_p-1 then 0):
  - ackp: oldest retained entry.
  - rdp: next entry to read.
  - wcp: commit boundary.
  - wrp: next write slot.
- Regions: unacked = [ackp, rdp), readable = [rdp, wcp), uncommitted = [wcp, wrp). The three count registers are kept explicitly; free = els_p - unacked - readable - uncommitted.
- Reset: all pointers 0, all counts 0, free_cnt_o = els_p, v_o = 0, ready_o = 1. Reset overrides every other input.
- ready_o = ~clr_v_i & (free_cnt_o != 0). Enqueue writes data_i at wrp, then wrp+1 and uncommitted+1.
- v_o = ~rollback_v_i & (readable_cnt_o != 0). data_o = mem[rdp], combinational (bsg_mem_1r1w, async read).
- yumi_i: rdp+1, readable-1, unacked+1.
- Commit: wcp <= wrp, including a same-cycle enqueue. The committed entries become readable; v_o rises the next cycle (enqueue-to-v_o latency = 1 cycle after commit).
- Drop: wrp <= wcp and uncommitted <= 0. A same-cycle enqueue is discarded, but the memory write is harmless.
- ack: ackp += ack_cnt_i (modular), unacked -= ack_cnt_i, free += ack_cnt_i. ack_cnt_i = 0 is a no-op.
  - Legal only when ack_cnt_i <= unacked_cnt_o (registered value). A same-cycle yumi cannot be acked.
- rollback: rdp <= ackp (post-ack value if ack is in the same cycle), readable += unacked, unacked <= 0. v_o is low this cycle, so yumi_i must be 0.
- clr: wrp, wcp <= rdp (post-yumi value), readable <= 0, uncommitted <= 0. Unacked entries are preserved.
  - clr beats commit/drop in the same cycle.
  - If rollback occurs in the same cycle, clr uses the pre-rollback rdp. The rewound unacked entries therefore survive and become readable.
- Write-side and read-side operations in the same cycle compose independently, except for the clr/rollback ordering above.
- Full case: free = 0 leaves ready_o low. Ack in that cycle raises ready_o the next cycle (no same-cycle bypass).
- Empty case: readable = 0 leaves v_o low even if uncommitted > 0.
- Simulation assertions (translate_off):
  - yumi_i & ~v_o.
  - ack_cnt_i > unacked_cnt_o.
  - Enqueue while full with ready_then_valid_p = 1.
  - rollback_v_i & yumi_i.
  - Counts summing above els_p.

Test Plan:
- els_p = 5: enqueue 3, no commit -> v_o = 0, uncommitted = 3. Commit -> next cycle v_o = 1, readable = 3, data_o = first word.
- Enqueue 5 entries with same-cycle commit on the 5th -> ready_o = 0, free = 0. Read 2, ack_cnt = 2 -> next cycle ready_o = 1, free = 2. Enqueue 2 more: pointers wrap to 0, 1 and data order is preserved.
- Commit 4 (A, B, C, D), read A, B, C, ack 1, rollback -> next cycle data_o = B, readable = 3, unacked = 0.
- Enqueue X, Y uncommitted, then drop in the same cycle as enqueue Z -> uncommitted = 0, wrp back to wcp. Next commit of W yields readable W only.
- Committed A, B, C; uncommitted D. Read A, then clr together with rollback -> A readable again; B, C, D gone; readable = 1.
- Reset asserted mid-stream (readable = 2, unacked = 1) -> next cycle all counts 0, free = els_p, v_o = 0, ready_o = 1.
